// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the BCD seven-segment scanner.
//   Segment patterns are active-low, ordered {a,b,c,d,e,f,g,dp}, with the
//   dp bit left at 1 (off); the scanner clears it separately.
//   ANODE_OFF is the all-dark anode select for the active-low, one-cold
//   anode bus.
package ssd_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low one-cold anode select for digit position k.
  function automatic logic [3:0] anode_sel(input logic [1:0] k);
    logic [3:0] onehot;
    onehot = 4'b0001 << k;
    return ~onehot;
  endfunction

  // Clear the active-low dp bit when the decimal point should be lit.
  function automatic logic [7:0] with_dp(input logic [7:0] seg, input logic dp);
    logic [7:0] res;
    res = seg;
    if (dp) begin
      res[0] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_ssd.sv
// bcd_to_ssd: combinational BCD to seven-segment decoder.
//   digit : in  4  BCD digit; values 10..15 are not legal BCD
//   seg   : out 8  active-low pattern {a,b,c,d,e,f,g,dp}, dp bit always 1
// Illegal codes show a dash (segment g only) so a corrupt counter value is
// visible on the display instead of silently looking like a valid digit.
module bcd_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_ssd_scanner.sv
// bcd_ssd_scanner: time-multiplexed driver for a common-anode 4-digit
// seven-segment display fed by BCD digit counters.
//   clk        : in  1   system clock
//   reset      : in  1   asynchronous, active-high reset
//   bcd_in     : in  16  four BCD digits, [15:12] = digit3 (MSD) .. [3:0] = digit0
//   dp_in      : in  4   per-digit decimal point, 1 = lit (used live)
//   digit_en   : in  4   per-digit enable, 1 = may be lit (used live)
//   ssd_ctl    : out 4   anode select, active-low one-cold, bit k = digit k
//   ssd_out    : out 8   segments, active-low {a,b,c,d,e,f,g,dp}
//   frame_tick : out 1   one-cycle pulse when a new frame starts
// Each digit slot lasts DIV_CNT clocks; four slots make a frame. The BCD
// digits are captured once per frame (when the slot wraps 3->0) so a
// counter rolling over mid-frame can never produce a torn display. Leading
// zeros on digits 3..1 are blanked when LZ_BLANK = 1.
module bcd_ssd_scanner
  import ssd_pkg::*;
#(
  parameter int DIV_CNT  = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  ssd_out,
  output logic        frame_tick
);

  localparam int DIV_W = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       slot;
  logic [15:0]      snapshot;

  logic             slot_end;
  logic             frame_end;

  logic [3:0]       zero_p0;
  logic [3:0]       blank_p0;
  logic [3:0]       digit_p0;
  logic [7:0]       seg_raw_p0;
  logic [7:0]       seg_p0;
  logic [3:0]       ctl_p0;
  logic             lit_p0;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (slot == 2'd3);

  // ---- stage 0: slot timing and per-frame snapshot ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      slot       <= 2'd0;
      snapshot   <= 16'h0000;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        div_cnt <= '0;
        slot    <= slot + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (frame_end) begin
        snapshot <= bcd_in;
      end
      frame_tick <= frame_end;
    end
  end

  // Zero detection per snapshot digit; illegal BCD is nonzero by construction.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      zero_p0[k] = (snapshot[4*k +: 4] == 4'h0);
    end
  end

  // A digit is a leading zero only if it and every more significant digit
  // are zero. Digit 0 always stays visible so a zero value reads "   0".
  always_comb begin
    blank_p0    = 4'b0000;
    blank_p0[3] = LZ_BLANK && zero_p0[3];
    blank_p0[2] = blank_p0[3] && zero_p0[2];
    blank_p0[1] = blank_p0[2] && zero_p0[1];
    blank_p0[0] = 1'b0;
  end

  always_comb begin
    digit_p0 = 4'h0;
    case (slot)
      2'd0:    digit_p0 = snapshot[3:0];
      2'd1:    digit_p0 = snapshot[7:4];
      2'd2:    digit_p0 = snapshot[11:8];
      default: digit_p0 = snapshot[15:12];
    endcase
  end

  bcd_to_ssd u_dec (
    .digit (digit_p0),
    .seg   (seg_raw_p0)
  );

  // A dark slot drives all segments off, including its decimal point.
  always_comb begin
    lit_p0 = digit_en[slot] && !blank_p0[slot];
    ctl_p0 = ANODE_OFF;
    seg_p0 = SEG_BLANK;
    if (lit_p0) begin
      ctl_p0 = anode_sel(slot);
      seg_p0 = with_dp(seg_raw_p0, dp_in[slot]);
    end
  end

  // ---- stage 1: registered display outputs ----
  // Anodes and segments update on the same edge so no ghosting appears
  // between slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssd_ctl <= ANODE_OFF;
      ssd_out <= SEG_BLANK;
    end else begin
      ssd_ctl <= ctl_p0;
      ssd_out <= seg_p0;
    end
  end

endmodule
